fg_sweep_ctrl: RTL and testbench
================================

Name: fg_sweep_ctrl

Overview:
Frequency/parameter sweep controller for the function generator's 7 x 8-bit config register file (CR0..CR6). It shares the single config write port between the host parallel interface and an internal sweep engine. The engine steps one selected CR from START to STOP by STEP every DWELL waveform periods. It sits between the input synchronizers and the config register bank.

Parameters:
DW, 8, config data width
AW, 3, config address width
NUM_CR, 7, number of FG config registers; addresses >= NUM_CR are never written
DWELL_W, 8, width of the dwell period counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
host_wr_i  in  1  host write strobe, already synchronized, active high, one cycle per write
host_sel_i  in  1  0 = FG config space, 1 = sweep register space
host_addr_i  in  AW  host register address
host_data_i  in  DW  host write data
fg_enable_i  in  1  FG running (synchronized enable)
period_done_i  in  1  one-cycle pulse from FG at each waveform period wrap
cr_wr_o  out  1  config register write strobe
cr_addr_o  out  AW  config register address
cr_data_o  out  DW  config register data
sweep_active_o  out  1  engine is in ARM/WAIT/WRITE
sweep_done_o  out  1  one-shot sweep finished; sticky until next start or reset

Behaviour:
- Reset: rst_n low on a rising clk edge.
  - cr_wr_o=0, cr_addr_o=0, cr_data_o=0, sweep_active_o=0, sweep_done_o=0.
  - Sweep registers: START=0, STOP=0xFF, STEP=1, DWELL=1, CTRL=0.
  - State IDLE, cur=0, dwell counter=0.
- Sweep register space (host_sel_i=1):
  - 0 START, 1 STOP, 2 STEP, 3 DWELL.
  - 4 CTRL: [0] RUN, [1] DOWN, [2] LOOP, [6:4] TGT (target CR address).
  - Addresses 5..7 are ignored.
  - Writing CTRL with RUN=1 from IDLE or DONE starts a sweep.
  - Writing RUN=0 aborts the sweep: return to IDLE next cycle, no further writes, target CR keeps its last value.
- Host FG writes (host_sel_i=0):
  - host_wr_i with addr < NUM_CR gives cr_wr_o=1, cr_addr_o=host_addr_i, cr_data_o=host_data_i on the next cycle (1-cycle registered latency).
  - addr >= NUM_CR produces no write.
- Arbitration: the host has priority.
  - If a pending sweep write collides with a host FG write in the same cycle, the sweep write stays in WRITE and issues on the first cycle without a host write.
  - A host write to the TGT register during a sweep is allowed; the engine overwrites it at its next step.
  - cur is not reloaded from the host write.
- States:
  - IDLE -> ARM on start. TGT >= NUM_CR is treated as a failed start: stay IDLE, CTRL.RUN cleared.
  - ARM: cur <= START, go to WRITE.
  - WRITE: issue cr_wr_o for TGT with cur (subject to arbitration), then go to WAIT with the dwell counter cleared.
  - WAIT: count period_done_i pulses, only while fg_enable_i=1. Pulses arriving while fg_enable_i=0 are ignored.
    - When count reaches max(DWELL,1): compute next and go to WRITE (or DONE).
  - DONE: sweep_done_o=1, sweep_active_o=0. Go to ARM on a new RUN write.
- Next-value arithmetic: DW+1 bit unsigned.
  - Up: nxt = cur + STEP. Overflow occurs if nxt > STOP or nxt[DW]=1.
  - Down: nxt = cur - STEP. Overflow occurs if a borrow occurs or nxt < STOP.
  - On overflow with LOOP=1: cur <= START and write it.
  - On overflow with LOOP=0 and cur != STOP: cur <= STOP, write, then DONE after that write's dwell.
  - On overflow with LOOP=0 and cur == STOP: DONE directly, no write.
  - STEP=0: cur is unchanged, rewritten every dwell, never finishes.
  - START beyond STOP in the sweep direction: first step overflows immediately.
- sweep_done_o clears on the cycle the engine enters ARM.
- Reset mid-sweep: everything returns to reset values; no write is issued in the reset cycle or the cycle after.

Test Plan:
- Host write sel=0, addr=5, data=0x32 -> next cycle cr_wr_o=1, addr=5, data=0x32; addr=7 -> no cr_wr_o.
- START=0x10, STOP=0x14, STEP=2, DWELL=1, TGT=5, RUN, fg_enable_i=1, periodic period_done_i -> CR5 writes 0x10, 0x12, 0x14, then sweep_done_o=1, no further writes.
- Same setup with LOOP=1 -> write sequence 0x10, 0x12, 0x14, 0x10, ...; sweep_done_o stays 0.
- Down mode START=0x05, STOP=0x00, STEP=3, DWELL=2 -> writes 0x05, 0x02, 0x00 with two period pulses between each, then DONE; fg_enable_i=0 pulses not counted.
- Host FG write in the same cycle the sweep write is due -> host write issues first, sweep write one cycle later with an unchanged value.
- rst_n low during WAIT -> all outputs 0, registers at reset values, no write issued until a new RUN.

Source files
------------

// File: rtl/fg_sweep_ctrl.sv
// fg_sweep_ctrl: shares the FG config register write port between host writes
// and a sweep engine that steps one config register from START to STOP by STEP
// every DWELL waveform periods. Host writes always win the port.
module fg_sweep_ctrl #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int NUM_CR  = 7,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_wr_i,
  input  logic          host_sel_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_data_i,
  input  logic          fg_enable_i,
  input  logic          period_done_i,
  output logic          cr_wr_o,
  output logic [AW-1:0] cr_addr_o,
  output logic [DW-1:0] cr_data_o,
  output logic          sweep_active_o,
  output logic          sweep_done_o
);

  localparam logic [AW:0] NUM_CR_W = (AW+1)'(NUM_CR);

  typedef enum logic [2:0] {IDLE, ARM, WRITE, WAIT, DONE} state_t;

  state_t state, state_nxt;

  logic [DW-1:0]      start_val, stop_val, step_val;
  logic [DWELL_W-1:0] dwell_val;
  logic               down, loop_mode;
  logic [AW-1:0]      tgt;

  logic [DW-1:0]      cur, cur_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt, dwell_eff, dwell_inc;
  logic               last_step, last_step_nxt;

  logic               host_fg_wr, ctrl_wr, start_req, start_ok, abort_req;
  logic               active, sweep_wr, ovf;
  logic [DW:0]        sum, diff;

  assign host_fg_wr = host_wr_i & ~host_sel_i & ({1'b0, host_addr_i} < NUM_CR_W);
  assign ctrl_wr    = host_wr_i & host_sel_i & (host_addr_i == AW'(4));
  assign active     = (state == ARM) | (state == WRITE) | (state == WAIT);
  assign start_req  = ctrl_wr & host_data_i[0] & ((state == IDLE) | (state == DONE));
  assign start_ok   = ({1'b0, host_data_i[4 +: AW]} < NUM_CR_W);
  assign abort_req  = ctrl_wr & ~host_data_i[0] & active;

  // Next-value arithmetic is one bit wider so carry/borrow flags the overflow.
  assign sum  = {1'b0, cur} + {1'b0, step_val};
  assign diff = {1'b0, cur} - {1'b0, step_val};
  assign ovf  = down ? (diff[DW] | (diff[DW-1:0] < stop_val))
                     : (sum[DW]  | (sum[DW-1:0]  > stop_val));

  assign dwell_eff = (dwell_val == '0) ? DWELL_W'(1) : dwell_val;
  assign dwell_inc = dwell_cnt + DWELL_W'(1);

  assign sweep_active_o = active;
  assign sweep_done_o   = (state == DONE);

  // Host-programmed sweep registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_val <= '0;
      stop_val  <= '1;
      step_val  <= DW'(1);
      dwell_val <= DWELL_W'(1);
      down      <= 1'b0;
      loop_mode <= 1'b0;
      tgt       <= '0;
    end else if (host_wr_i && host_sel_i) begin
      case (host_addr_i)
        AW'(0): start_val <= host_data_i;
        AW'(1): stop_val  <= host_data_i;
        AW'(2): step_val  <= host_data_i;
        AW'(3): dwell_val <= DWELL_W'(host_data_i);
        AW'(4): begin
          down      <= host_data_i[1];
          loop_mode <= host_data_i[2];
          tgt       <= host_data_i[4 +: AW];
        end
        default: ;
      endcase
    end
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      dwell_cnt <= '0;
      last_step <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      last_step <= last_step_nxt;
    end
  end

  // Next-state, step computation and sweep write request.
  // last_step marks a clamp-to-STOP write so DONE follows its dwell even when
  // STEP=0 would otherwise keep rewriting STOP forever.
  always_comb begin
    state_nxt     = state;
    cur_nxt       = cur;
    dwell_cnt_nxt = dwell_cnt;
    last_step_nxt = last_step;
    sweep_wr      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_req) state_nxt = start_ok ? ARM : IDLE;
      end
      ARM: begin
        cur_nxt       = start_val;
        last_step_nxt = 1'b0;
        state_nxt     = WRITE;
      end
      WRITE: begin
        if (!host_fg_wr) begin
          sweep_wr      = 1'b1;
          dwell_cnt_nxt = '0;
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (fg_enable_i && period_done_i) begin
          if (dwell_inc >= dwell_eff) begin
            dwell_cnt_nxt = '0;
            if (last_step) begin
              state_nxt = DONE;
            end else if (!ovf) begin
              cur_nxt   = down ? diff[DW-1:0] : sum[DW-1:0];
              state_nxt = WRITE;
            end else if (loop_mode) begin
              cur_nxt   = start_val;
              state_nxt = WRITE;
            end else if (cur != stop_val) begin
              cur_nxt       = stop_val;
              last_step_nxt = 1'b1;
              state_nxt     = WRITE;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            dwell_cnt_nxt = dwell_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_req) begin
      state_nxt = IDLE;
      sweep_wr  = 1'b0;
    end
  end

  // Registered config write port; host write takes precedence over the engine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cr_wr_o   <= 1'b0;
      cr_addr_o <= '0;
      cr_data_o <= '0;
    end else begin
      cr_wr_o <= host_fg_wr | sweep_wr;
      if (host_fg_wr) begin
        cr_addr_o <= host_addr_i;
        cr_data_o <= host_data_i;
      end else if (sweep_wr) begin
        cr_addr_o <= tgt;
        cr_data_o <= cur;
      end
    end
  end

endmodule

// File: tb/tb_fg_sweep_ctrl.sv
// tb_fg_sweep_ctrl: randomized and directed stimulus for fg_sweep_ctrl, with
// a list-based model of the expected sweep write sequence and dwell counts.
module tb_fg_sweep_ctrl;

  localparam int DW      = 8;
  localparam int AW      = 3;
  localparam int NUM_CR  = 7;
  localparam int DWELL_W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_wr, host_sel;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          fg_enable, period_done;
  logic          cr_wr;
  logic [AW-1:0] cr_addr;
  logic [DW-1:0] cr_data;
  logic          sweep_active, sweep_done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  bit pulse_on   = 1'b0;
  bit en_rand    = 1'b0;
  bit pulse_seen = 1'b0;

  always #5 clk = ~clk;

  fg_sweep_ctrl #(.DW(DW), .AW(AW), .NUM_CR(NUM_CR), .DWELL_W(DWELL_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_wr_i     (host_wr),
    .host_sel_i    (host_sel),
    .host_addr_i   (host_addr),
    .host_data_i   (host_data),
    .fg_enable_i   (fg_enable),
    .period_done_i (period_done),
    .cr_wr_o       (cr_wr),
    .cr_addr_o     (cr_addr),
    .cr_data_o     (cr_data),
    .sweep_active_o(sweep_active),
    .sweep_done_o  (sweep_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Advance to the next falling edge; record the enabled-pulse seen by the
  // last rising edge, then drive fresh pulse/enable inputs and drop host_wr.
  task automatic cyc();
    @(negedge clk);
    pulse_seen = period_done & fg_enable;
    host_wr    = 1'b0;
    if (pulse_on) begin
      period_done = ($urandom_range(0, 2) == 0);
      fg_enable   = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end else begin
      period_done = 1'b0;
      fg_enable   = 1'b1;
    end
  endtask

  task automatic host_write(input bit sel, input int addr, input int data);
    host_sel  = sel;
    host_addr = addr[AW-1:0];
    host_data = data[DW-1:0];
    host_wr   = 1'b1;
    cyc();
  endtask

  function automatic logic [7:0] ctrl(input bit run, input bit dn, input bit lp, input int tg);
    logic [2:0] t;
    t = tg[2:0];
    return {1'b0, t, 1'b0, lp, dn, run};
  endfunction

  task automatic run_sweep(input bit prog, input int st, input int sp, input int stp,
                           input int dw, input bit dn, input bit lp, input int tg,
                           input int maxw, input bit enr);
    int q[$];
    int cur, nxt, dwe, idx, pc, budget, nw;
    bit fin, exp_done, seen_done;
    if (prog) begin
      host_write(1'b1, 0, st);
      host_write(1'b1, 1, sp);
      host_write(1'b1, 2, stp);
      host_write(1'b1, 3, dw);
    end
    // Expected value list straight from the sweep rules, in plain integers.
    q = {};
    q.push_back(st);
    cur = st; fin = 1'b0; exp_done = 1'b0;
    while (!exp_done && q.size() <= maxw) begin
      nxt = dn ? cur - stp : cur + stp;
      if (fin) exp_done = 1'b1;
      else if (dn ? (nxt < sp) : (nxt > sp)) begin
        if (lp) q.push_back(st);
        else if (cur != sp) begin q.push_back(sp); fin = 1'b1; end
        else exp_done = 1'b1;
      end else q.push_back(nxt);
      cur = q[$];
    end
    dwe = (dw == 0) ? 1 : dw;

    en_rand  = enr;
    pulse_on = 1'b1;
    host_write(1'b1, 4, ctrl(1'b1, dn, lp, tg));
    check("active_on_start", sweep_active, 1);
    check("done_clear_on_start", sweep_done, 0);

    idx = 0; pc = 0; seen_done = 1'b0;
    for (budget = 0; budget < 3000; budget++) begin
      cyc();
      if (cr_wr) begin
        if (idx >= q.size()) begin
          check("write_count", idx + 1, q.size());
          break;
        end
        check("sweep_addr", cr_addr, tg);
        check("sweep_data", cr_data, q[idx]);
        if (idx > 0) check("dwell_pulses", pc, dwe);
        idx++;
        pc = 0;
        if (!exp_done && idx >= maxw) break;
      end else begin
        if (pulse_seen) pc++;
        if (sweep_done) begin
          seen_done = 1'b1;
          check("writes_before_done", idx, q.size());
          check("final_dwell", pc, dwe);
          break;
        end
      end
    end

    if (exp_done) begin
      check("done_seen", seen_done, 1);
      nw = 0;
      repeat (20) begin cyc(); if (cr_wr) nw++; end
      check("no_write_after_done", nw, 0);
      check("done_sticky", sweep_done, 1);
      check("inactive_when_done", sweep_active, 0);
    end else begin
      check("write_budget_reached", idx, maxw);
      check("not_done_while_running", sweep_done, 0);
      host_write(1'b1, 4, ctrl(1'b0, dn, lp, tg));
      check("abort_no_write", cr_wr, 0);
      check("abort_idle", sweep_active, 0);
      nw = 0;
      repeat (15) begin cyc(); if (cr_wr) nw++; end
      check("no_write_after_abort", nw, 0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, sp, stp, dw, tg, nw, na;
    bit dn, lp, enr;

    rst_n = 1'b0; host_wr = 1'b0; host_sel = 1'b0; host_addr = '0; host_data = '0;
    fg_enable = 1'b1; period_done = 1'b0;
    cyc();
    cyc();
    check("rst_cr_wr", cr_wr, 0);
    check("rst_cr_addr", cr_addr, 0);
    check("rst_cr_data", cr_data, 0);
    check("rst_active", sweep_active, 0);
    check("rst_done", sweep_done, 0);
    rst_n = 1'b1;
    cyc();

    // Host FG writes: valid addresses pass with one cycle latency.
    host_write(1'b0, 5, 8'h32);
    check("host_wr5", cr_wr, 1);
    check("host_addr5", cr_addr, 5);
    check("host_data5", cr_data, 8'h32);
    host_write(1'b0, 7, 8'h99);
    check("host_addr7_blocked", cr_wr, 0);
    host_write(1'b0, 6, 8'h5A);
    check("host_wr6", cr_wr, 1);
    check("host_addr6", cr_addr, 6);
    check("host_data6", cr_data, 8'h5A);
    host_write(1'b1, 5, 8'h77);
    check("sweep_space_no_cr_wr", cr_wr, 0);

    // Directed sweeps.
    run_sweep(1'b1, 8'h10, 8'h14, 2, 1, 1'b0, 1'b0, 5, 10, 1'b0);
    run_sweep(1'b1, 8'h10, 8'h14, 2, 1, 1'b0, 1'b1, 5, 8, 1'b0);
    run_sweep(1'b1, 8'h05, 8'h00, 3, 2, 1'b1, 1'b0, 5, 10, 1'b1);
    run_sweep(1'b1, 8'h20, 8'h10, 4, 1, 1'b0, 1'b0, 1, 10, 1'b1);
    run_sweep(1'b1, 8'h33, 8'h40, 0, 1, 1'b0, 1'b0, 2, 5, 1'b0);

    // Start with an out-of-range target is refused.
    host_write(1'b1, 4, ctrl(1'b1, 1'b0, 1'b0, 7));
    check("bad_tgt_no_start", sweep_active, 0);
    nw = 0; na = 0;
    repeat (10) begin cyc(); if (cr_wr) nw++; if (sweep_active) na++; end
    check("bad_tgt_no_write", nw, 0);
    check("bad_tgt_stays_idle", na, 0);

    // Host write collides with the first sweep write.
    pulse_on = 1'b0;
    cyc();
    host_write(1'b1, 0, 8'h40);
    host_write(1'b1, 1, 8'h50);
    host_write(1'b1, 2, 4);
    host_write(1'b1, 3, 1);
    host_write(1'b1, 4, ctrl(1'b1, 1'b0, 1'b0, 2));
    cyc();
    check("no_write_in_arm", cr_wr, 0);
    host_sel = 1'b0; host_addr = 3'd2; host_data = 8'hA5; host_wr = 1'b1;
    cyc();
    check("collide_host_wr", cr_wr, 1);
    check("collide_host_addr", cr_addr, 2);
    check("collide_host_data", cr_data, 8'hA5);
    cyc();
    check("collide_sweep_wr", cr_wr, 1);
    check("collide_sweep_addr", cr_addr, 2);
    check("collide_sweep_data", cr_data, 8'h40);
    host_write(1'b1, 4, ctrl(1'b0, 1'b0, 1'b0, 2));
    check("collide_abort_idle", sweep_active, 0);

    // Randomized sweeps.
    for (int i = 0; i < 10; i++) begin
      st  = int'($urandom_range(0, 255));
      sp  = int'($urandom_range(0, 255));
      stp = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 64));
      dw  = int'($urandom_range(0, 3));
      dn  = 1'($urandom_range(0, 1));
      lp  = 1'($urandom_range(0, 1));
      tg  = int'($urandom_range(0, NUM_CR - 1));
      enr = 1'($urandom_range(0, 1));
      run_sweep(1'b1, st, sp, stp, dw, dn, lp, tg, 10, enr);
    end

    // Reset during WAIT, then confirm register defaults with a bare RUN.
    en_rand = 1'b0;
    pulse_on = 1'b1;
    host_write(1'b1, 0, 8'h80);
    host_write(1'b1, 1, 8'h90);
    host_write(1'b1, 2, 3);
    host_write(1'b1, 3, 2);
    host_write(1'b1, 4, ctrl(1'b1, 1'b1, 1'b1, 4));
    nw = 0;
    for (int b = 0; b < 200; b++) begin
      cyc();
      if (cr_wr) begin nw = 1; break; end
    end
    check("first_write_before_reset", nw, 1);
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    check("midrst_cr_wr", cr_wr, 0);
    check("midrst_cr_addr", cr_addr, 0);
    check("midrst_cr_data", cr_data, 0);
    check("midrst_active", sweep_active, 0);
    check("midrst_done", sweep_done, 0);
    rst_n = 1'b1;
    cyc();
    check("post_rst_no_write", cr_wr, 0);
    nw = 0;
    repeat (30) begin cyc(); if (cr_wr) nw++; end
    check("no_write_until_run", nw, 0);
    run_sweep(1'b0, 0, 255, 1, 1, 1'b0, 1'b0, 3, 6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
